// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory and presents one instruction plus its PC to decode.
// A one-entry skid buffer catches a fetch that completes while decode
// stalls. Redirects flush the stage; an abandoned in-flight request is
// drained in DISCARD so its late data is never mistaken for a new fetch.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_IM_Req,
  output logic [31:0] o_IM_Addr,
  input  logic        i_IM_Ack,
  input  logic [31:0] i_IM_Data,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_Redirect_PC,
  output logic [31:0] o_Instr,
  output logic [31:0] o_PC,
  output logic        o_Valid,
  output logic        o_Ex_inst_misaligned
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    FULL     = 2'd1,
    DISCARD  = 2'd2,
    MISALIGN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        mis_q, mis_d;
  // Address of the request being drained in DISCARD, and where to go after.
  logic [31:0] disc_addr_q, disc_addr_d;
  logic        disc_mis_q, disc_mis_d;

  logic req;
  logic consume;
  logic slot_free;
  logic tgt_mis;

  assign req       = (state_q == FETCH) || (state_q == DISCARD);
  assign consume   = valid_q & ~i_Stall;
  assign slot_free = ~valid_q | consume;
  assign tgt_mis   = |i_Redirect_PC[1:0];

  // Request is withdrawn combinationally while reset is held.
  assign o_IM_Req  = req & ~i_rst;
  assign o_IM_Addr = (state_q == DISCARD) ? disc_addr_q : pc_q;

  assign o_Instr              = valid_q ? instr_q : NOP_INSTR;
  assign o_PC                 = opc_q;
  assign o_Valid              = valid_q;
  assign o_Ex_inst_misaligned = mis_q;

  // Next-state and datapath update; redirect outranks stall and ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    opc_d        = opc_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    mis_d        = mis_q;
    disc_addr_d  = disc_addr_q;
    disc_mis_d   = disc_mis_q;

    if (i_Redirect) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_vld_d = 1'b0;
      pc_d       = i_Redirect_PC;
      mis_d      = tgt_mis;
      if (req && !i_IM_Ack) begin
        // Outstanding request must still complete at its original address.
        state_d    = DISCARD;
        disc_mis_d = tgt_mis;
        if (state_q == FETCH) disc_addr_d = pc_q;
      end else begin
        state_d = tgt_mis ? MISALIGN : FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (i_IM_Ack) begin
            pc_d = pc_q + 32'd4;
            if (slot_free) begin
              valid_d = 1'b1;
              instr_d = i_IM_Data;
              opc_d   = pc_q;
            end else begin
              skid_vld_d   = 1'b1;
              skid_instr_d = i_IM_Data;
              skid_pc_d    = pc_q;
              state_d      = FULL;
            end
          end else if (consume) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        FULL: begin
          if (consume) begin
            valid_d    = 1'b1;
            instr_d    = skid_instr_q;
            opc_d      = skid_pc_q;
            skid_vld_d = 1'b0;
            state_d    = FETCH;
          end
        end
        DISCARD: begin
          if (i_IM_Ack) state_d = disc_mis_q ? MISALIGN : FETCH;
        end
        MISALIGN: begin
          state_d = MISALIGN;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      opc_q        <= 32'd0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'd0;
      mis_q        <= 1'b0;
      disc_addr_q  <= 32'd0;
      disc_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      mis_q        <= mis_d;
      disc_addr_q  <= disc_addr_d;
      disc_mis_q   <= disc_mis_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: outputs are checked on the falling
// edge, then the inputs for the next rising edge are driven.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        mis;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_RESET(32'h0), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_IM_Req(im_req), .o_IM_Addr(im_addr),
    .i_IM_Ack(im_ack), .i_IM_Data(im_data),
    .i_Stall(stall), .i_Redirect(redir), .i_Redirect_PC(redir_pc),
    .o_Instr(instr), .o_PC(pc), .o_Valid(valid),
    .o_Ex_inst_misaligned(mis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic a, input logic [31:0] d, input logic s,
                       input logic r, input logic [31:0] rpc);
    im_ack = a; im_data = d; stall = s; redir = r; redir_pc = rpc;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_req",   {31'd0, im_req}, 32'd0);
    chk("rst_valid", {31'd0, valid},  32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc",    pc, 32'd0);
    chk("rst_mis",   {31'd0, mis}, 32'd0);
    rst = 1'b0;

    // Back-to-back fetch with ack every cycle
    @(negedge clk);
    chk("f0_addr", im_addr, 32'h0);
    chk("f0_req",  {31'd0, im_req}, 32'd1);
    drive(1, 32'h0050_0093, 0, 0, 0);
    @(negedge clk);
    chk("f1_valid", {31'd0, valid}, 32'd1);
    chk("f1_pc",    pc, 32'h0);
    chk("f1_instr", instr, 32'h0050_0093);
    chk("f1_addr",  im_addr, 32'h4);
    drive(1, 32'h00A0_0113, 0, 0, 0);
    @(negedge clk);
    chk("f2_pc",    pc, 32'h4);
    chk("f2_instr", instr, 32'h00A0_0113);
    chk("f2_addr",  im_addr, 32'h8);

    // Late stall with ack in the same cycle lands in the skid
    drive(1, 32'h0030_0193, 1, 0, 0);
    @(negedge clk);
    chk("full_req",   {31'd0, im_req}, 32'd0);
    chk("full_pc",    pc, 32'h4);
    chk("full_valid", {31'd0, valid}, 32'd1);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("full_hold_pc", pc, 32'h4);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("skid_pc",    pc, 32'h8);
    chk("skid_instr", instr, 32'h0030_0193);
    chk("skid_addr",  im_addr, 32'hC);
    chk("skid_req",   {31'd0, im_req}, 32'd1);

    // Redirect while a request is outstanding: drain old address
    drive(0, 0, 0, 1, 32'h100);
    @(negedge clk);
    chk("disc_addr0",  im_addr, 32'hC);
    chk("disc_req0",   {31'd0, im_req}, 32'd1);
    chk("disc_valid0", {31'd0, valid}, 32'd0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("disc_addr1",  im_addr, 32'hC);
    chk("disc_valid1", {31'd0, valid}, 32'd0);
    drive(1, 32'hBAD0_BAD0, 0, 0, 0);
    @(negedge clk);
    chk("disc_valid2", {31'd0, valid}, 32'd0);
    chk("disc_instr2", instr, NOP);
    chk("disc_next",   im_addr, 32'h100);

    // Redirect coinciding with ack: data dropped
    drive(1, 32'hDEAD_BEEF, 0, 1, 32'h300);
    @(negedge clk);
    chk("rack_valid", {31'd0, valid}, 32'd0);
    chk("rack_instr", instr, NOP);
    chk("rack_addr",  im_addr, 32'h300);

    // Misaligned redirect (ack coincides, so straight to MISALIGN)
    drive(1, 32'h1111_1111, 0, 1, 32'h102);
    @(negedge clk);
    chk("mis_flag",  {31'd0, mis}, 32'd1);
    chk("mis_req",   {31'd0, im_req}, 32'd0);
    chk("mis_valid", {31'd0, valid}, 32'd0);
    drive(1, 32'h2222_2222, 0, 0, 0);
    @(negedge clk);
    chk("mis_hold_req", {31'd0, im_req}, 32'd0);
    chk("mis_hold_val", {31'd0, valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h200);
    @(negedge clk);
    chk("unmis_flag", {31'd0, mis}, 32'd0);
    chk("unmis_addr", im_addr, 32'h200);
    chk("unmis_req",  {31'd0, im_req}, 32'd1);
    drive(1, 32'h0000_0011, 0, 0, 0);
    @(negedge clk);
    chk("resume_pc",    pc, 32'h200);
    chk("resume_instr", instr, 32'h0000_0011);

    // Misaligned redirect with request outstanding: DISCARD then MISALIGN
    drive(0, 0, 0, 1, 32'h203);
    @(negedge clk);
    chk("dmis_addr", im_addr, 32'h204);
    chk("dmis_req",  {31'd0, im_req}, 32'd1);
    chk("dmis_flag", {31'd0, mis}, 32'd1);
    drive(1, 32'h3333_3333, 0, 0, 0);
    @(negedge clk);
    chk("dmis_req2",   {31'd0, im_req}, 32'd0);
    chk("dmis_valid2", {31'd0, valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h400);
    @(negedge clk);
    chk("dmis_exit", im_addr, 32'h400);

    // Fill skid, redirect out of FULL, then enter DISCARD and reset
    drive(1, 32'h0000_0044, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'h0000_0055, 1, 0, 0);
    @(negedge clk);
    chk("r_full_req", {31'd0, im_req}, 32'd0);
    drive(0, 0, 1, 1, 32'h500);
    @(negedge clk);
    chk("r_fetch_addr", im_addr, 32'h500);
    drive(0, 0, 0, 1, 32'h600);
    @(negedge clk);
    chk("r_disc_addr", im_addr, 32'h500);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_req",   {31'd0, im_req}, 32'd0);
    chk("async_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_addr", im_addr, 32'h0);

    // PC wraps from 0xFFFFFFFC to 0
    drive(1, 32'h0, 0, 1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr0", im_addr, 32'hFFFF_FFFC);
    drive(1, 32'h0000_0077, 0, 0, 0);
    @(negedge clk);
    chk("wrap_pc",   pc, 32'hFFFF_FFFC);
    chk("wrap_addr", im_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
